// File: rtl/carregador_matrizes_pkg.sv
// rtl/carregador_matrizes_pkg.sv - op codes, FSM encoding and helpers for the matrix loader
package carregador_matrizes_pkg;

   localparam logic [2:0] OP_ADD      = 3'd0;
   localparam logic [2:0] OP_SUB      = 3'd1;
   localparam logic [2:0] OP_MUL      = 3'd2;
   localparam logic [2:0] OP_ESC      = 3'd3;
   localparam logic [2:0] OP_TRANS    = 3'd4;
   localparam logic [2:0] OP_OPOSTA   = 3'd5;
   localparam logic [2:0] OP_DET      = 3'd6;
   localparam logic [2:0] OP_INVALIDA = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ESCALAR,
      ST_CARREGA_A,
      ST_CARREGA_B,
      ST_PRONTO
   } estado_t;

   // Binary ops (add/sub/mul) are the only ones that read matrix B.
   function automatic logic usa_b(input logic [2:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/carregador_matrizes_contador_elementos.sv
// rtl/carregador_matrizes_contador_elementos.sv - modulo counter indexing matrix slots during a fill
module contador_elementos #(
   parameter int MODULO = 9,
   parameter int CW     = $clog2(MODULO)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          fim_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign fim_o = (cnt_q == CW'(MODULO - 1));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = fim_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/carregador_matrizes.sv
// rtl/carregador_matrizes.sv - registered front end that assembles op, scalar, A and B from a beat stream
module carregador_matrizes
   import carregador_matrizes_pkg::*;
#(
   parameter int N     = 3,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_dado,
   input  logic                     in_valido,
   output logic                     in_pronto,
   output logic [2:0]               operacao,
   output logic [WIDTH-1:0]         escalar,
   output logic [N*N*WIDTH-1:0]     A,
   output logic [N*N*WIDTH-1:0]     B,
   output logic                     valido,
   input  logic                     consumido,
   output logic                     erro
);

   localparam int NN = N * N;
   localparam int CW = $clog2(NN);

   estado_t                estado_q, estado_d;
   logic [2:0]             op_q, op_d;
   logic [WIDTH-1:0]       esc_q, esc_d;
   logic [NN*WIDTH-1:0]    a_q, a_d;
   logic [NN*WIDTH-1:0]    b_q, b_d;
   logic                   erro_q, erro_d;

   logic [2:0]             op_in;
   logic                   aceita;
   logic                   cnt_en;
   logic                   cnt_clr;
   logic [CW-1:0]          cnt;
   logic                   cnt_fim;

   assign op_in     = in_dado[2:0];
   assign in_pronto = (estado_q != ST_PRONTO);
   assign aceita    = in_valido && in_pronto;
   assign cnt_en    = aceita && (estado_q == ST_CARREGA_A || estado_q == ST_CARREGA_B);
   assign cnt_clr   = (estado_q == ST_IDLE);

   contador_elementos #(
      .MODULO (NN),
      .CW     (CW)
   ) u_contador (
      .clk   (clk),
      .rst   (rst),
      .en_i  (cnt_en),
      .clr_i (cnt_clr),
      .cnt_o (cnt),
      .fim_o (cnt_fim)
   );

   always_comb begin
      estado_d = estado_q;
      op_d     = op_q;
      esc_d    = esc_q;
      a_d      = a_q;
      b_d      = b_q;
      erro_d   = 1'b0;

      unique case (estado_q)
         ST_IDLE: begin
            if (aceita) begin
               if (op_in == OP_INVALIDA) begin
                  erro_d = 1'b1;
               end else begin
                  op_d = op_in;
                  if (!usa_b(op_in)) begin
                     b_d = '0;
                  end
                  if (op_in == OP_ESC) begin
                     estado_d = ST_ESCALAR;
                  end else begin
                     esc_d    = '0;
                     estado_d = ST_CARREGA_A;
                  end
               end
            end
         end
         ST_ESCALAR: begin
            if (aceita) begin
               esc_d    = in_dado;
               estado_d = ST_CARREGA_A;
            end
         end
         ST_CARREGA_A: begin
            if (aceita) begin
               for (int k = 0; k < NN; k++) begin
                  if (cnt == CW'(k)) begin
                     a_d[k*WIDTH +: WIDTH] = in_dado;
                  end
               end
               if (cnt_fim) begin
                  estado_d = usa_b(op_q) ? ST_CARREGA_B : ST_PRONTO;
               end
            end
         end
         ST_CARREGA_B: begin
            if (aceita) begin
               for (int k = 0; k < NN; k++) begin
                  if (cnt == CW'(k)) begin
                     b_d[k*WIDTH +: WIDTH] = in_dado;
                  end
               end
               if (cnt_fim) begin
                  estado_d = ST_PRONTO;
               end
            end
         end
         ST_PRONTO: begin
            if (consumido) begin
               estado_d = ST_IDLE;
            end
         end
         default: begin
            estado_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= ST_IDLE;
         op_q     <= '0;
         esc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         op_q     <= op_d;
         esc_q    <= esc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         erro_q   <= erro_d;
      end
   end

   assign operacao = op_q;
   assign escalar  = esc_q;
   assign A        = a_q;
   assign B        = b_q;
   assign valido   = (estado_q == ST_PRONTO);
   assign erro     = erro_q;

endmodule
